psx_mem_arbiter: RTL and testbench

//  Two-client arbiter placed directly upstream of the PSX-side DDR adapter port.

---
 rtl/psx_mem_pkg.sv | 54 +++++
 rtl/psx_arb_picker.sv | 42 ++++
 rtl/psx_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_psx_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_mem_pkg.sv
// -----------------------------------------------------------------------------
// psx_mem_pkg
//   Shared types and constants for the PSX-side memory arbiter.
//   - CMD_* : command size encodings understood by the DDR adapter
//   - arb_state_t : arbiter FSM states
//   - mem_req_t : one latched client request (write flag, size, block
//     address, sub-address, write mask, write data)
//   - make_req(): packs loose client fields into a mem_req_t
// -----------------------------------------------------------------------------
package psx_mem_pkg;

    localparam int PSX_ADDR_W = 15;
    localparam int PSX_DATA_W = 256;
    localparam int PSX_MASK_W = 16;

    localparam logic [1:0] CMD_8BYTE  = 2'd0;
    localparam logic [1:0] CMD_32BYTE = 2'd1;
    localparam logic [1:0] CMD_4BYTE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic [PSX_ADDR_W-1:0] addr;
        logic [2:0]            sub;
        logic [PSX_MASK_W-1:0] mask;
        logic [PSX_DATA_W-1:0] data;
    } mem_req_t;

    function automatic mem_req_t make_req(
        input logic                  write,
        input logic [1:0]            size,
        input logic [PSX_ADDR_W-1:0] addr,
        input logic [2:0]            sub,
        input logic [PSX_MASK_W-1:0] mask,
        input logic [PSX_DATA_W-1:0] data
    );
        mem_req_t r;
        r.write = write;
        r.size  = size;
        r.addr  = addr;
        r.sub   = sub;
        r.mask  = mask;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/psx_arb_picker.sv
// -----------------------------------------------------------------------------
// psx_arb_picker
//   Chooses which of two pending requests is granted this cycle.
//   Configuration macro: PSX_ARB_ROUND_ROBIN_EN
//     defined   : on contention the client that did NOT win last time wins
//     undefined : fixed priority, client 0 always wins; last_grant_i unused
// Ports
//   req_i        [1:0] pending requests, bit N = client N
//   last_grant_i       client index of the most recent grant
//   grant_o      [1:0] one-hot grant (all zero when nothing is requested)
// -----------------------------------------------------------------------------
module psx_arb_picker (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

`ifdef PSX_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            // Alternate: hand the bus to whoever was not served last.
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_i;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_o = 2'b00;
        if (req_i[0]) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/psx_mem_arbiter.sv
// -----------------------------------------------------------------------------
// psx_mem_arbiter
//   Two-client arbiter in front of the PSX-side DDR adapter. Client 0 is the
//   GPU pixel/cache path, client 1 the CPU/DMA VRAM path. One command is in
//   flight at a time; read data is routed back to the client that issued it.
//   Clients only see req/ack; the adapter busy signal stays internal.
//   Configuration macro: PSX_ARB_ROUND_ROBIN_EN (round-robin on contention;
//   otherwise fixed priority to client 0 and no last-grant register).
// Ports
//   i_clk, i_nRst               clock, asynchronous active-low reset
//   i_cN_req/write/size/addr/
//   sub/mask/data               client N request and its fields (N = 0,1)
//   o_cN_ack                    1-cycle pulse, request captured this cycle
//   o_cN_rdValid                1-cycle pulse, o_rdData belongs to client N
//   o_rdData                    read data shared by both clients
//   o_command .. o_dataToMem    command and fields to the adapter
//   i_busyMem, i_dataValidMem,
//   i_dataMem                   adapter status and read data
// -----------------------------------------------------------------------------
module psx_mem_arbiter
    import psx_mem_pkg::*;
#(
    // Must match the PSX_* widths in psx_mem_pkg (the latched request type
    // is built from those).
    parameter int ADDR_W = PSX_ADDR_W,
    parameter int DATA_W = PSX_DATA_W,
    parameter int MASK_W = PSX_MASK_W
) (
    input  logic              i_clk,
    input  logic              i_nRst,

    input  logic              i_c0_req,
    input  logic              i_c0_write,
    input  logic [1:0]        i_c0_size,
    input  logic [ADDR_W-1:0] i_c0_addr,
    input  logic [2:0]        i_c0_sub,
    input  logic [MASK_W-1:0] i_c0_mask,
    input  logic [DATA_W-1:0] i_c0_data,
    output logic              o_c0_ack,
    output logic              o_c0_rdValid,

    input  logic              i_c1_req,
    input  logic              i_c1_write,
    input  logic [1:0]        i_c1_size,
    input  logic [ADDR_W-1:0] i_c1_addr,
    input  logic [2:0]        i_c1_sub,
    input  logic [MASK_W-1:0] i_c1_mask,
    input  logic [DATA_W-1:0] i_c1_data,
    output logic              o_c1_ack,
    output logic              o_c1_rdValid,

    output logic [DATA_W-1:0] o_rdData,

    output logic              o_command,
    output logic              o_writeElseRead,
    output logic [1:0]        o_commandSize,
    output logic [ADDR_W-1:0] o_targetAddr,
    output logic [2:0]        o_subAddr,
    output logic [MASK_W-1:0] o_writeMask,
    output logic [DATA_W-1:0] o_dataToMem,

    input  logic              i_busyMem,
    input  logic              i_dataValidMem,
    input  logic [DATA_W-1:0] i_dataMem
);

    arb_state_t        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              owner_q, owner_d;
    logic              command_q, command_d;
    logic [1:0]        rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    mem_req_t          c0_req_fields, c1_req_fields;
    logic [1:0]        grant;
    logic              grant_en;
    logic              picker_last_grant;

    assign c0_req_fields = make_req(i_c0_write, i_c0_size, i_c0_addr,
                                    i_c0_sub, i_c0_mask, i_c0_data);
    assign c1_req_fields = make_req(i_c1_write, i_c1_size, i_c1_addr,
                                    i_c1_sub, i_c1_mask, i_c1_data);

    psx_arb_picker u_picker (
        .req_i        ({i_c1_req, i_c0_req}),
        .last_grant_i (picker_last_grant),
        .grant_o      (grant)
    );

`ifdef PSX_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign last_grant_d = grant_en ? grant[1] : last_grant_q;

    // Resets to client 1 so the first contention goes to client 0.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign picker_last_grant = last_grant_q;
`else
    assign picker_last_grant = 1'b1;
`endif

    // Next-state logic. Fields are latched only on a grant, so the adapter
    // sees them stable from issue until the transaction completes.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        owner_d    = owner_q;
        command_d  = 1'b0;
        rd_valid_d = 2'b00;
        rd_data_d  = rd_data_q;
        grant_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Busy sampled high here blocks any new command.
                if ((i_c0_req || i_c1_req) && !i_busyMem) begin
                    grant_en  = 1'b1;
                    owner_d   = grant[1];
                    req_d     = grant[1] ? c1_req_fields : c0_req_fields;
                    command_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // The adapter raises busy one cycle after the command, so
                // busy is not meaningful yet.
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (req_q.write) begin
                    if (!i_busyMem) begin
                        state_d = IDLE;
                    end
                end else if (i_dataValidMem) begin
                    rd_data_d  = i_dataMem;
                    rd_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            owner_q    <= 1'b0;
            command_q  <= 1'b0;
            rd_valid_q <= 2'b00;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            owner_q    <= owner_d;
            command_q  <= command_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Ack is combinational in the grant cycle; gating with the reset keeps
    // every output low while reset is held.
    assign o_c0_ack        = grant_en & grant[0] & i_nRst;
    assign o_c1_ack        = grant_en & grant[1] & i_nRst;
    assign o_c0_rdValid    = rd_valid_q[0];
    assign o_c1_rdValid    = rd_valid_q[1];
    assign o_rdData        = rd_data_q;

    assign o_command       = command_q;
    assign o_writeElseRead = req_q.write;
    assign o_commandSize   = req_q.size;
    assign o_targetAddr    = req_q.addr;
    assign o_subAddr       = req_q.sub;
    assign o_writeMask     = req_q.mask;
    assign o_dataToMem     = req_q.data;

endmodule

// File: tb/tb_psx_mem_arbiter.sv
// Directed testbench for psx_mem_arbiter with a small behavioural adapter.
module tb_psx_mem_arbiter;

    logic         clk;
    logic         rst_n;

    logic         c0_req, c0_write, c1_req, c1_write;
    logic [1:0]   c0_size, c1_size;
    logic [14:0]  c0_addr, c1_addr;
    logic [2:0]   c0_sub, c1_sub;
    logic [15:0]  c0_mask, c1_mask;
    logic [255:0] c0_data, c1_data;

    logic         c0_ack, c1_ack, c0_rdv, c1_rdv;
    logic [255:0] rd_data;
    logic         command, wer;
    logic [1:0]   cmd_size;
    logic [14:0]  taddr;
    logic [2:0]   sub_addr;
    logic [15:0]  wmask;
    logic [255:0] data_to_mem;

    logic         busy_mem, valid_mem;
    logic [255:0] data_mem;

    // Adapter model state (driven only by the model process)
    logic         m_busy, m_valid, m_read;
    logic [255:0] m_data;
    int           m_cnt;
    // Stimulus controls (driven only by the main initial block)
    int           model_lat;
    logic [255:0] read_pattern;
    logic         busy_force, valid_force;
    logic [255:0] stray_data;

    int n_checks;
    int n_pass;

    assign busy_mem  = m_busy | busy_force;
    assign valid_mem = m_valid | valid_force;
    assign data_mem  = valid_force ? stray_data : m_data;

    psx_mem_arbiter dut (
        .i_clk           (clk),
        .i_nRst          (rst_n),
        .i_c0_req        (c0_req),
        .i_c0_write      (c0_write),
        .i_c0_size       (c0_size),
        .i_c0_addr       (c0_addr),
        .i_c0_sub        (c0_sub),
        .i_c0_mask       (c0_mask),
        .i_c0_data       (c0_data),
        .o_c0_ack        (c0_ack),
        .o_c0_rdValid    (c0_rdv),
        .i_c1_req        (c1_req),
        .i_c1_write      (c1_write),
        .i_c1_size       (c1_size),
        .i_c1_addr       (c1_addr),
        .i_c1_sub        (c1_sub),
        .i_c1_mask       (c1_mask),
        .i_c1_data       (c1_data),
        .o_c1_ack        (c1_ack),
        .o_c1_rdValid    (c1_rdv),
        .o_rdData        (rd_data),
        .o_command       (command),
        .o_writeElseRead (wer),
        .o_commandSize   (cmd_size),
        .o_targetAddr    (taddr),
        .o_subAddr       (sub_addr),
        .o_writeMask     (wmask),
        .o_dataToMem     (data_to_mem),
        .i_busyMem       (busy_mem),
        .i_dataValidMem  (valid_mem),
        .i_dataMem       (data_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adapter: on a command, busy for model_lat cycles; a read ends with a
    // one-cycle data-valid pulse in the same cycle busy falls.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_read  = 1'b0;
            m_cnt   = 0;
        end else begin
            m_valid = 1'b0;
            if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    if (m_read) begin
                        m_valid = 1'b1;
                        m_data  = read_pattern;
                    end
                end
            end else if (command) begin
                m_busy = 1'b1;
                m_cnt  = model_lat;
                m_read = !wer;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_clients();
        c0_req = 1'b0; c0_write = 1'b0; c0_size = 2'd0; c0_addr = '0;
        c0_sub = 3'd0; c0_mask = '0; c0_data = '0;
        c1_req = 1'b0; c1_write = 1'b0; c1_size = 2'd0; c1_addr = '0;
        c1_sub = 3'd0; c1_mask = '0; c1_data = '0;
    endtask

    task automatic test_reset();
        idle_clients();
        c0_req = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (c0_ack !== 1'b0) $display("FAIL reset_ack0 got=%b exp=0", c0_ack); else n_pass++;
        n_checks++;
        if (command !== 1'b0) $display("FAIL reset_command got=%b exp=0", command); else n_pass++;
        n_checks++;
        if ({c0_rdv, c1_rdv, c1_ack} !== 3'b000) $display("FAIL reset_pulses got=%b exp=000", {c0_rdv, c1_rdv, c1_ack}); else n_pass++;
        n_checks++;
        if (rd_data !== '0) $display("FAIL reset_rdData got=%h exp=0", rd_data); else n_pass++;
        n_checks++;
        if ({wer, cmd_size, taddr, sub_addr, wmask} !== '0) $display("FAIL reset_cmd_fields got=%h exp=0", {wer, cmd_size, taddr, sub_addr, wmask}); else n_pass++;
        n_checks++;
        if (data_to_mem !== '0) $display("FAIL reset_dataToMem got=%h exp=0", data_to_mem); else n_pass++;
        c0_req = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("txn reset: outputs idle after reset");
    endtask

    task automatic test_read_c0();
        logic got;
        logic bad;
        got = 1'b0;
        bad = 1'b0;
        model_lat = 3;
        read_pattern = {32{8'hA5}};
        c0_write = 1'b0; c0_size = 2'd1; c0_addr = 15'h0123; c0_sub = 3'd0;
        c0_req = 1'b1;
        #1;
        n_checks++;
        if ({c0_ack, c1_ack} !== 2'b10) $display("FAIL read_ack got=%b exp=10", {c0_ack, c1_ack}); else n_pass++;
        tick();
        c0_req = 1'b0;
        n_checks++;
        if (command !== 1'b1) $display("FAIL read_command got=%b exp=1", command); else n_pass++;
        n_checks++;
        if ({wer, cmd_size, taddr} !== {1'b0, 2'd1, 15'h0123}) $display("FAIL read_fields got=%h exp=%h", {wer, cmd_size, taddr}, {1'b0, 2'd1, 15'h0123}); else n_pass++;
        tick();
        n_checks++;
        if (command !== 1'b0) $display("FAIL read_command_pulse got=%b exp=0", command); else n_pass++;
        for (int i = 0; i < 20 && !got; i++) begin
            if (c1_rdv) bad = 1'b1;
            if (c0_rdv) got = 1'b1; else tick();
        end
        n_checks++;
        if (got !== 1'b1) $display("FAIL read_rdValid0 got=%b exp=1", got); else n_pass++;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL read_no_rdValid1 got=%b exp=0", bad); else n_pass++;
        n_checks++;
        if (rd_data !== {32{8'hA5}}) $display("FAIL read_rdData got=%h exp=%h", rd_data, {32{8'hA5}}); else n_pass++;
        tick();
        n_checks++;
        if (c0_rdv !== 1'b0) $display("FAIL read_rdValid_pulse got=%b exp=0", c0_rdv); else n_pass++;
        $display("txn read c0 addr=0123 size=1 data=%h", rd_data);
    endtask

    task automatic test_write_c1();
        logic bad;
        bad = 1'b0;
        model_lat = 3;
        c1_write = 1'b1; c1_size = 2'd2; c1_addr = 15'h7ABC; c1_sub = 3'd1;
        c1_mask = 16'h000F; c1_data = {8{32'hDEADBEEF}};
        c1_req = 1'b1;
        #1;
        n_checks++;
        if ({c0_ack, c1_ack} !== 2'b01) $display("FAIL write_ack got=%b exp=01", {c0_ack, c1_ack}); else n_pass++;
        tick();
        c1_req = 1'b0;
        n_checks++;
        if (command !== 1'b1) $display("FAIL write_command got=%b exp=1", command); else n_pass++;
        n_checks++;
        if ({wer, cmd_size, sub_addr, taddr, wmask} !== {1'b1, 2'd2, 3'd1, 15'h7ABC, 16'h000F})
            $display("FAIL write_fields got=%h exp=%h", {wer, cmd_size, sub_addr, taddr, wmask}, {1'b1, 2'd2, 3'd1, 15'h7ABC, 16'h000F});
        else n_pass++;
        n_checks++;
        if (data_to_mem !== {8{32'hDEADBEEF}}) $display("FAIL write_data got=%h exp=%h", data_to_mem, {8{32'hDEADBEEF}}); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (c0_rdv || c1_rdv) bad = 1'b1;
        end
        n_checks++;
        if (data_to_mem !== {8{32'hDEADBEEF}}) $display("FAIL write_data_stable got=%h exp=%h", data_to_mem, {8{32'hDEADBEEF}}); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (c0_rdv || c1_rdv) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL write_no_rdValid got=%b exp=0", bad); else n_pass++;
        $display("txn write c1 addr=7abc size=2 sub=1");
    endtask

    task automatic test_busy_hold();
        logic bad;
        bad = 1'b0;
        model_lat = 3;
        busy_force = 1'b1;
        c0_write = 1'b1; c0_size = 2'd0; c0_addr = 15'h0055; c0_data = {64{4'h3}};
        c0_req = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (c0_ack || command) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL busy_hold_blocked got=%b exp=0", bad); else n_pass++;
        busy_force = 1'b0;
        #1;
        n_checks++;
        if (c0_ack !== 1'b1) $display("FAIL busy_hold_ack got=%b exp=1", c0_ack); else n_pass++;
        tick();
        c0_req = 1'b0;
        n_checks++;
        if (command !== 1'b1) $display("FAIL busy_hold_command got=%b exp=1", command); else n_pass++;
        for (int i = 0; i < 10; i++) tick();
        $display("txn busy-hold c0 write served after busy fell");
    endtask

    task automatic test_stray_valid();
        logic bad;
        bad = 1'b0;
        model_lat = 5;
        c0_write = 1'b1; c0_size = 2'd1; c0_addr = 15'h0100; c0_data = {64{4'h9}};
        c0_req = 1'b1;
        tick();
        c0_req = 1'b0;
        tick();
        tick();
        valid_force = 1'b1;
        stray_data = {32{8'h3C}};
        tick();
        valid_force = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (c0_rdv || c1_rdv) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL stray_no_rdValid got=%b exp=0", bad); else n_pass++;
        n_checks++;
        if (rd_data !== {32{8'hA5}}) $display("FAIL stray_rdData_kept got=%h exp=%h", rd_data, {32{8'hA5}}); else n_pass++;
        $display("txn stray data-valid during c0 write ignored");
    endtask

    task automatic test_reset_mid_read();
        logic got;
        logic bad;
        got = 1'b0;
        bad = 1'b0;
        model_lat = 8;
        read_pattern = {32{8'h77}};
        c0_write = 1'b0; c0_size = 2'd1; c0_addr = 15'h0456; c0_sub = 3'd5; c0_mask = 16'hFFFF;
        c0_req = 1'b1;
        tick();
        c0_req = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({command, wer, cmd_size, taddr, sub_addr, wmask} !== '0)
            $display("FAIL async_reset_cmd got=%h exp=0", {command, wer, cmd_size, taddr, sub_addr, wmask});
        else n_pass++;
        n_checks++;
        if (rd_data !== '0) $display("FAIL async_reset_rdData got=%h exp=0", rd_data); else n_pass++;
        n_checks++;
        if ({c0_ack, c1_ack, c0_rdv, c1_rdv} !== 4'b0000) $display("FAIL async_reset_pulses got=%b exp=0000", {c0_ack, c1_ack, c0_rdv, c1_rdv}); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_lat = 2;
        read_pattern = {32{8'h5A}};
        c1_write = 1'b0; c1_size = 2'd0; c1_addr = 15'h0042; c1_sub = 3'd2;
        c1_req = 1'b1;
        #1;
        n_checks++;
        if ({c0_ack, c1_ack} !== 2'b01) $display("FAIL post_reset_ack got=%b exp=01", {c0_ack, c1_ack}); else n_pass++;
        tick();
        c1_req = 1'b0;
        n_checks++;
        if ({command, taddr, sub_addr} !== {1'b1, 15'h0042, 3'd2}) $display("FAIL post_reset_cmd got=%h exp=%h", {command, taddr, sub_addr}, {1'b1, 15'h0042, 3'd2}); else n_pass++;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (c0_rdv) bad = 1'b1;
            if (c1_rdv) got = 1'b1;
        end
        n_checks++;
        if ({got, bad} !== 2'b10) $display("FAIL post_reset_rdValid got=%b exp=10", {got, bad}); else n_pass++;
        n_checks++;
        if (rd_data !== {32{8'h5A}}) $display("FAIL post_reset_rdData got=%h exp=%h", rd_data, {32{8'h5A}}); else n_pass++;
        $display("txn reset mid-read dropped; c1 read served data=%h", rd_data);
    endtask

    task automatic test_contention();
        logic [3:0] seen;
        logic [3:0] exp_seq;
        int         n;
        logic       both;
        logic       got1;
`ifdef PSX_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b1010;   // bit r = client granted in round r
`else
        exp_seq = 4'b0000;
`endif
        seen = 4'b0000;
        n = 0;
        both = 1'b0;
        got1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_lat = 2;
        c0_write = 1'b1; c0_size = 2'd1; c0_addr = 15'h0010;
        c1_write = 1'b1; c1_size = 2'd1; c1_addr = 15'h0020;
        c0_req = 1'b1;
        c1_req = 1'b1;
        #1;
        for (int i = 0; i < 80 && n < 4; i++) begin
            if (c0_ack && c1_ack) both = 1'b1;
            if (c0_ack || c1_ack) begin
                seen[n] = c1_ack;
                $display("txn contention round %0d granted c%0d", n, c1_ack);
                n++;
            end
            tick();
        end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (r >= n) $display("FAIL contention_round%0d got=none exp=c%0d", r, exp_seq[r]);
            else if (seen[r] !== exp_seq[r]) $display("FAIL contention_round%0d got=c%0d exp=c%0d", r, seen[r], exp_seq[r]);
            else n_pass++;
        end
        n_checks++;
        if (both !== 1'b0) $display("FAIL contention_double_ack got=%b exp=0", both); else n_pass++;
        c0_req = 1'b0;
        #1;
        for (int i = 0; i < 20 && !got1; i++) begin
            if (c1_ack) got1 = 1'b1; else tick();
        end
        n_checks++;
        if (got1 !== 1'b1) $display("FAIL contention_c1_after_c0 got=%b exp=1", got1); else n_pass++;
        tick();
        c1_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        $display("txn contention: c1 served once c0 went idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b1;
        busy_force = 1'b0;
        valid_force = 1'b0;
        stray_data = '0;
        read_pattern = '0;
        model_lat = 3;
        m_data = '0;
        idle_clients();
        tick();
        test_reset();
        test_read_c0();
        test_write_c1();
        test_busy_hold();
        test_stray_valid();
        test_reset_mid_read();
        test_contention();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
